alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing the single combinational RV32I ALU between NUM_REQ requesters
//  (port 0 = execute stage, port 1 = branch/address-gen unit). Grants one request per cycle, drives the
//  ALU operand/opcode inputs, registers the ALU result into a one-entry response buffer with backpressure.
// PARAMETERS
//  NUM_REQ  2   number of requesters (>=2)
//  XLEN     32  operand/result width
//  TAG_W    4   requester-supplied tag width, returned unchanged with the result
// PORTS
//  clk            in   1              clock, rising edge
//  rst_n          in   1              async active-low reset
//  req_valid      in   NUM_REQ        request valid per requester
//  req_ready      out  NUM_REQ        request accepted this cycle (one-hot or zero)
//  req_opcode     in   7*NUM_REQ      packed opcode, requester i at [7*i+:7]
//  req_funct3     in   3*NUM_REQ      packed funct3
//  req_funct7     in   7*NUM_REQ      packed funct7
//  req_op_a       in   XLEN*NUM_REQ   packed rs1 value
//  req_op_b       in   XLEN*NUM_REQ   packed rs2 value / sign-extended immediate
//  req_tag        in   TAG_W*NUM_REQ  packed tag
//  alu_opcode     out  7              to ALU opcode input
//  alu_funct3     out  3              to ALU funct3 input
//  alu_funct7     out  7              to ALU funct7 input
//  alu_op_a       out  XLEN           to ALU rs1 value input
//  alu_op_b       out  XLEN           to ALU second-operand input
//  alu_result     in   XLEN           from ALU result output (combinational, same cycle)
//  rsp_valid      out  1              response buffer full
//  rsp_ready      in   1              consumer accepts response
//  rsp_id         out  $clog2(NUM_REQ) index of requester owning the response
//  rsp_tag        out  TAG_W          tag of the granted request
//  rsp_result     out  XLEN           registered ALU result
//  rsp_err        out  1              opcode was neither OP (0110011) nor OP-IMM (0010011)
// BEHAVIOUR
//  - Reset (async, rst_n=0): rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_result=0, rsp_err=0, rr pointer=0
//    (requester 0 highest priority first), FSM=EMPTY. req_ready=0 and alu_* =0 while in reset.
//  - FSM: EMPTY (buffer empty) / FULL (buffer holds response). can_accept = EMPTY | (FULL & rsp_ready).
//  - Grant: among req_valid, first index at or after rr pointer (wrapping NUM_REQ-1 -> 0) is granted.
//    req_ready[g]=can_accept for granted g; all others 0. req_ready depends combinationally on rsp_ready.
//  - Handshake: transfer when req_valid[i] & req_ready[i]. Requester holds all fields stable while
//    valid & !ready; valid may not drop before acceptance.
//  - ALU drive: alu_* = granted requester's fields whenever a grant exists (even if !can_accept);
//    all zero when no req_valid.
//  - Capture: on transfer, at next edge rsp_result<=alu_result (0 if err), rsp_id<=g, rsp_tag<=tag,
//    rsp_err<=unsupported opcode, FSM->FULL, rr pointer<=g+1 mod NUM_REQ. Latency: accept cycle N ->
//    rsp_valid cycle N+1. Throughput 1/cycle with rsp_ready held 1.
//  - Drain: FULL & rsp_ready & no transfer -> EMPTY. FULL & rsp_ready & transfer -> stays FULL, new data.
//  - FULL & !rsp_ready: all rsp_* held bit-stable, req_ready=0, rr pointer unchanged.
//  - Pointer advances only on transfer; a continuously-valid requester waits at most NUM_REQ-1 grants.
//  - Result bits are exactly alu_result; no width change. rsp_err responses still consume a grant.
//  - Reset asserted mid-operation: buffered response discarded immediately (no clock needed);
//    requesters re-issue after reset release. First grant after release is cycle 1 after rst_n rises.
// STRUCTURE
//  - alu_pkg: XLEN, OPC_OP=7'b0110011, OPC_OP_IMM=7'b0010011, funct3 codes (ADD..AND),
//    FUNCT7_ALT=7'b0100000, FSM state typedef {EMPTY, FULL}.
//  - Sub-module rr_arbiter (NUM_REQ): req vector + pointer -> one-hot grant + encoded index.
//  - Top: field mux, can_accept logic, response register, FSM, pointer register.
// TESTING
//  1. rst_n=0 with req_valid=2'b11 -> req_ready=0, rsp_valid=0, rsp_*=0; after release req0 granted first.
//  2. req0 ADDI (opc 0010011,f3 000) a=5,b=7,tag=3 -> req_ready[0]=1 cycle N; cycle N+1 rsp_valid=1,
//     rsp_result=12, rsp_id=0, rsp_tag=3, rsp_err=0.
//  3. req_valid=2'b11 held, rsp_ready=1 -> grants 0,1,0,1...; one response per cycle, ids alternate.
//  4. rsp_ready=0 after one accept -> req_ready=2'b00, rsp_* stable 5 cycles; rsp_ready=1 -> same-cycle
//     drain + new accept, rsp_valid stays 1 with next result.
//  5. req1 SUB (opc 0110011,f3 000,f7 0100000) a=3,b=5 -> 0xFFFFFFFE; opc 0000011 -> rsp_result=0, rsp_err=1.
//  6. rst_n pulsed low mid-FULL between clock edges -> rsp_valid=0 immediately, pointer back to 0.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// rtl/alu_share_arbiter_pkg.sv - shared RV32I ALU encodings and arbiter FSM state type
package alu_share_arbiter_pkg;

  localparam int XLEN = 32;

  // Major opcodes the shared ALU understands
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // funct3 codes for the integer register/immediate group
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // funct7 selecting SUB / SRA
  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

  // Response buffer occupancy
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // True for the two opcodes the ALU is allowed to evaluate
  function automatic logic is_alu_opcode(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_OP_IMM);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// rtl/alu_share_arbiter_rr_arbiter.sv - round-robin pick of one request starting at a pointer
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  // Scan upward from the pointer, wrapping, and take the first asserted request
  always_comb begin
    int cand;
    cand  = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr_i) + k) % NUM_REQ;
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one combinational ALU between requesters with a one-entry response buffer
module alu_share_arbiter #(
  parameter  int NUM_REQ = 2,
  parameter  int XLEN    = 32,
  parameter  int TAG_W   = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [7*NUM_REQ-1:0]     req_opcode,
  input  logic [3*NUM_REQ-1:0]     req_funct3,
  input  logic [7*NUM_REQ-1:0]     req_funct7,
  input  logic [XLEN*NUM_REQ-1:0]  req_op_a,
  input  logic [XLEN*NUM_REQ-1:0]  req_op_b,
  input  logic [TAG_W*NUM_REQ-1:0] req_tag,
  output logic [6:0]               alu_opcode,
  output logic [2:0]               alu_funct3,
  output logic [6:0]               alu_funct7,
  output logic [XLEN-1:0]          alu_op_a,
  output logic [XLEN-1:0]          alu_op_b,
  input  logic [XLEN-1:0]          alu_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDX_W-1:0]         rsp_id,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic [XLEN-1:0]          rsp_result,
  output logic                     rsp_err
);

  import alu_share_arbiter_pkg::*;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   rsp_id_q, rsp_id_d;
  logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
  logic [XLEN-1:0]    rsp_result_q, rsp_result_d;
  logic               rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0] gnt_oh;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic               grant_live;
  logic               can_accept;
  logic               transfer;
  logic [IDX_W-1:0]   next_ptr;

  logic [6:0]         sel_opcode;
  logic [2:0]         sel_funct3;
  logic [6:0]         sel_funct7;
  logic [XLEN-1:0]    sel_op_a;
  logic [XLEN-1:0]    sel_op_b;
  logic [TAG_W-1:0]   sel_tag;
  logic               sel_err;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt_oh),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // Nothing is granted while reset is held, so ready and the ALU drive stay quiet
  assign grant_live = gnt_any & rst_n;
  assign can_accept = (state_q == EMPTY) | rsp_ready;
  assign transfer   = grant_live & can_accept;
  assign req_ready  = transfer ? gnt_oh : '0;
  assign next_ptr   = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;

  // Route the granted requester's fields to the ALU, zero when idle
  always_comb begin
    sel_opcode = '0;
    sel_funct3 = '0;
    sel_funct7 = '0;
    sel_op_a   = '0;
    sel_op_b   = '0;
    sel_tag    = '0;
    if (grant_live) begin
      sel_opcode = req_opcode[7*int'(gnt_idx) +: 7];
      sel_funct3 = req_funct3[3*int'(gnt_idx) +: 3];
      sel_funct7 = req_funct7[7*int'(gnt_idx) +: 7];
      sel_op_a   = req_op_a[XLEN*int'(gnt_idx) +: XLEN];
      sel_op_b   = req_op_b[XLEN*int'(gnt_idx) +: XLEN];
      sel_tag    = req_tag[TAG_W*int'(gnt_idx) +: TAG_W];
    end
    sel_err = ~is_alu_opcode(sel_opcode);
  end

  assign alu_opcode = sel_opcode;
  assign alu_funct3 = sel_funct3;
  assign alu_funct7 = sel_funct7;
  assign alu_op_a   = sel_op_a;
  assign alu_op_b   = sel_op_b;

  // Next buffer contents: load on transfer, empty on a plain drain, otherwise hold
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    rsp_id_d     = rsp_id_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    if (transfer) begin
      state_d      = FULL;
      ptr_d        = next_ptr;
      rsp_id_d     = gnt_idx;
      rsp_tag_d    = sel_tag;
      rsp_result_d = sel_err ? '0 : alu_result;
      rsp_err_d    = sel_err;
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  // Buffer state, round-robin pointer and registered response fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      ptr_q        <= '0;
      rsp_id_q     <= '0;
      rsp_tag_q    <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      rsp_id_q     <= rsp_id_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign rsp_valid  = (state_q == FULL);
  assign rsp_id     = rsp_id_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter with a behavioural model
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int XW = 32;
  localparam int TW = 4;
  localparam int IW = 1;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [TW-1:0] tag;
    logic [XW-1:0] res;
    logic          err;
  } rsp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid, req_ready;
  logic [7*N-1:0]  req_opcode, req_funct7;
  logic [3*N-1:0]  req_funct3;
  logic [XW*N-1:0] req_op_a, req_op_b;
  logic [TW*N-1:0] req_tag;
  logic [6:0]      alu_opcode, alu_funct7;
  logic [2:0]      alu_funct3;
  logic [XW-1:0]   alu_op_a, alu_op_b, alu_result;
  logic            rsp_valid, rsp_ready, rsp_err;
  logic [IW-1:0]   rsp_id;
  logic [TW-1:0]   rsp_tag;
  logic [XW-1:0]   rsp_result;

  logic [6:0]  r_opc [N];
  logic [2:0]  r_f3  [N];
  logic [6:0]  r_f7  [N];
  logic [31:0] r_a   [N];
  logic [31:0] r_b   [N];
  logic [3:0]  r_tag [N];
  bit          pend  [N];
  bit          taken [N];

  rsp_t sb[$];
  int   model_ptr;
  bit   model_full;
  bit   rnd_mode;
  int   vectors = 0;
  int   miscompares = 0;

  alu_share_arbiter #(.NUM_REQ(N), .XLEN(XW), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_funct3(req_funct3), .req_funct7(req_funct7),
    .req_op_a(req_op_a), .req_op_b(req_op_b), .req_tag(req_tag),
    .alu_opcode(alu_opcode), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_tag(rsp_tag), .rsp_result(rsp_result), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // RV32I integer ALU; unsupported opcodes yield junk so forced-zero results are visible
  function automatic logic [31:0] ref_alu(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [31:0] a,
                                          input logic [31:0] b);
    if (opc != OPC_OP && opc != OPC_OP_IMM) return a ^ b ^ 32'hDEADBEEF;
    case (f3)
      F3_ADD:  return (opc == OPC_OP && f7[5]) ? a - b : a + b;
      F3_SLL:  return a << b[4:0];
      F3_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      F3_SLTU: return (a < b) ? 32'd1 : 32'd0;
      F3_XOR:  return a ^ b;
      F3_SR:   return f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      F3_OR:   return a | b;
      default: return a & b;
    endcase
  endfunction

  always_comb alu_result = ref_alu(alu_opcode, alu_funct3, alu_funct7, alu_op_a, alu_op_b);

  always_comb begin
    req_valid  = '0;
    req_opcode = '0;
    req_funct3 = '0;
    req_funct7 = '0;
    req_op_a   = '0;
    req_op_b   = '0;
    req_tag    = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = pend[i];
      req_opcode[7*i +: 7]   = r_opc[i];
      req_funct3[3*i +: 3]   = r_f3[i];
      req_funct7[7*i +: 7]   = r_f7[i];
      req_op_a[XW*i +: XW]   = r_a[i];
      req_op_b[XW*i +: XW]   = r_b[i];
      req_tag[TW*i +: TW]    = r_tag[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag);
    r_opc[i] = opc;
    r_f3[i]  = f3;
    r_f7[i]  = f7;
    r_a[i]   = a;
    r_b[i]   = b;
    r_tag[i] = tag;
    pend[i]  = 1'b1;
  endtask

  task automatic rand_req(input int i);
    int          sel;
    logic [6:0]  opc;
    logic [11:0] imm;
    logic [31:0] b;
    sel = $urandom_range(0, 9);
    imm = 12'($urandom);
    if (sel < 5) begin
      opc = OPC_OP;
      b   = $urandom;
    end else if (sel < 9) begin
      opc = OPC_OP_IMM;
      b   = {{20{imm[11]}}, imm};
    end else begin
      opc = 7'($urandom_range(0, 127));
      b   = $urandom;
    end
    set_req(i, opc, 3'($urandom_range(0, 7)),
            ($urandom_range(0, 1) == 1) ? FUNCT7_ALT : 7'd0,
            ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
            b, 4'($urandom_range(0, 15)));
  endtask

  // Requester/consumer driver: retire accepted requests, then randomize in random mode
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (taken[i]) begin
        pend[i]  = 1'b0;
        taken[i] = 1'b0;
      end
    end
    if (rnd_mode) begin
      rsp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 3) != 0) rand_req(i);
    end
  end

  // Reference model: rotating-priority grant, buffer occupancy and expected responses
  always @(negedge clk) begin
    int           g;
    int           c;
    bit           can;
    logic [N-1:0] exp_ready;
    rsp_t         e;
    if (rst_n) begin
      chk("rsp_valid", 32'(rsp_valid), 32'(model_full));
      can = !model_full || rsp_ready;
      g = -1;
      for (int k = 0; k < N; k++) begin
        c = (model_ptr + k) % N;
        if (g < 0 && pend[c]) g = c;
      end
      exp_ready = '0;
      if (g >= 0 && can) exp_ready[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      if (g >= 0) begin
        chk("alu_opcode", 32'(alu_opcode), 32'(r_opc[g]));
        chk("alu_op_a", alu_op_a, r_a[g]);
        chk("alu_op_b", alu_op_b, r_b[g]);
      end else begin
        chk("alu_idle", 32'(alu_opcode) | alu_op_a | alu_op_b, 32'd0);
      end
      if (g >= 0 && can) begin
        e.id  = IW'(g);
        e.tag = r_tag[g];
        e.err = !(r_opc[g] == OPC_OP || r_opc[g] == OPC_OP_IMM);
        e.res = e.err ? 32'd0 : ref_alu(r_opc[g], r_f3[g], r_f7[g], r_a[g], r_b[g]);
        sb.push_back(e);
        taken[g]   = 1'b1;
        model_ptr  = (g + 1) % N;
        model_full = 1'b1;
      end else if (model_full && rsp_ready) begin
        model_full = 1'b0;
      end
    end
  end

  // Monitor: compare the presented response with the scoreboard head, pop on acceptance
  always @(negedge clk) begin
    rsp_t h;
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_underflow: got rsp_valid=1 tag=%0d expected no response", rsp_tag);
      end else begin
        h = sb[0];
        chk("rsp_id", 32'(rsp_id), 32'(h.id));
        chk("rsp_tag", 32'(rsp_tag), 32'(h.tag));
        chk("rsp_result", rsp_result, h.res);
        chk("rsp_err", 32'(rsp_err), 32'(h.err));
        if (rsp_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    rnd_mode   = 1'b0;
    rsp_ready  = 1'b1;
    model_ptr  = 0;
    model_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i]  = 1'b0;
      taken[i] = 1'b0;
      set_req(i, 7'd0, 3'd0, 7'd0, 32'd0, 32'd0, 4'd0);
      pend[i]  = 1'b0;
    end
    rst_n = 1'b0;
    set_req(0, OPC_OP_IMM, F3_ADD, 7'd0, 32'd5, 32'd7, 4'd3);
    set_req(1, OPC_OP, F3_ADD, FUNCT7_ALT, 32'd3, 32'd5, 4'd9);
    repeat (2) @(negedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_result", rsp_result, 32'd0);
    chk("reset_rsp_tag_id_err", 32'({rsp_tag, rsp_id, rsp_err}), 32'd0);
    chk("reset_alu_drive", 32'(alu_opcode) | alu_op_a | alu_op_b, 32'd0);

    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("first_grant", 32'(req_ready), 32'b01);
    @(negedge clk); #1;
    chk("addi_valid", 32'(rsp_valid), 32'd1);
    chk("addi_result", rsp_result, 32'd12);
    chk("addi_id", 32'(rsp_id), 32'd0);
    chk("addi_tag", 32'(rsp_tag), 32'd3);
    chk("addi_err", 32'(rsp_err), 32'd0);
    chk("second_grant", 32'(req_ready), 32'b10);
    @(negedge clk); #1;
    chk("sub_result", rsp_result, 32'hFFFF_FFFE);
    chk("sub_id", 32'(rsp_id), 32'd1);

    @(posedge clk); #2 set_req(0, 7'b0000011, F3_ADD, 7'd0, 32'h1234, 32'h10, 4'd5);
    @(negedge clk);
    @(negedge clk); #1;
    chk("bad_err", 32'(rsp_err), 32'd1);
    chk("bad_result", rsp_result, 32'd0);
    chk("bad_tag", 32'(rsp_tag), 32'd5);

    @(posedge clk); #2;
    rsp_ready = 1'b0;
    set_req(0, OPC_OP, F3_ADD, 7'd0, 32'd100, 32'd1, 4'd6);
    set_req(1, OPC_OP, F3_XOR, 7'd0, 32'hF0F0_0000, 32'h0FF0_FFFF, 4'd7);
    @(negedge clk); #1;
    chk("bp_accept", 32'(req_ready), 32'b10);
    @(negedge clk); #1;
    chk("bp_tag", 32'(rsp_tag), 32'd7);
    chk("bp_result", rsp_result, 32'hFF00_FFFF);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("bp_ready_low", 32'(req_ready), 32'd0);
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_result", rsp_result, 32'hFF00_FFFF);
      chk("bp_hold_tag", 32'(rsp_tag), 32'd7);
    end
    @(posedge clk); #2 rsp_ready = 1'b1;
    @(negedge clk); #1;
    chk("bp_release_ready", 32'(req_ready), 32'b01);
    @(negedge clk); #1;
    chk("bp_next_valid", 32'(rsp_valid), 32'd1);
    chk("bp_next_tag", 32'(rsp_tag), 32'd6);
    chk("bp_next_result", rsp_result, 32'd101);

    rnd_mode = 1'b1;
    repeat (4000) @(posedge clk);
    rnd_mode = 1'b0;
    #2 rsp_ready = 1'b1;
    c = 0;
    while ((pend[0] || pend[1] || rsp_valid) && c < 50) begin
      @(posedge clk); #2;
      c++;
    end
    chk("drain_done", 32'({pend[0], pend[1], rsp_valid}), 32'd0);

    @(posedge clk); #2;
    rsp_ready = 1'b0;
    set_req(0, OPC_OP, F3_OR, 7'd0, 32'h0000_00FF, 32'h0000_FF00, 4'd10);
    @(negedge clk);
    @(posedge clk); #3;
    chk("pre_reset_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(rsp_valid), 32'd0);
    chk("async_rst_result", rsp_result, 32'd0);
    chk("async_rst_tag", 32'(rsp_tag), 32'd0);
    sb.delete();
    model_full = 1'b0;
    model_ptr  = 0;
    pend[0] = 1'b1;
    set_req(1, OPC_OP_IMM, F3_SLT, 7'd0, 32'hFFFF_FFFF, 32'd1, 4'd11);
    #1;
    chk("async_rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    chk("post_reset_grant", 32'(req_ready), 32'b01);
    repeat (6) @(posedge clk);
    #2;
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
